// File: rtl/note_pkg.sv
// Shared definitions for the note sequencer: default geometry and FSM state encoding.
package note_pkg;

  localparam int unsigned DEF_LANES = 4;
  localparam int unsigned DEF_DEPTH = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/note_sequencer_if.sv
// Chart-load write bus and row presentation outputs of the note sequencer.
//   slave  (sequencer): takes wr_en/wr_addr/wr_data, drives wr_err and the row outputs
//   master (host/view): drives the write bus, observes wr_err and the row outputs
interface note_sequencer_if
  import note_pkg::*;
#(
  parameter int unsigned LANES = DEF_LANES,
  parameter int unsigned AW    = $clog2(DEF_DEPTH)
) ();

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [LANES-1:0] wr_data;
  logic             wr_err;
  logic [LANES-1:0] display_signal;
  logic             row_valid;
  logic [AW-1:0]    position;

  modport slave (
    input  wr_en, wr_addr, wr_data,
    output wr_err, display_signal, row_valid, position
  );

  modport master (
    output wr_en, wr_addr, wr_data,
    input  wr_err, display_signal, row_valid, position
  );

endinterface

// File: rtl/chart_ram.sv
// Chart storage: simple dual-port RAM, one write port, one read port with a
// registered (1-cycle) read. Contents are intentionally not reset.
//   clk           : clock
//   we/waddr/wdata: write port
//   re/raddr      : read request, data appears on rdata the next cycle
//   rdata         : registered read data, holds when re is low
module chart_ram #(
  parameter int unsigned LANES = 4,
  parameter int unsigned DEPTH = 128,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [LANES-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [LANES-1:0] rdata
);

  logic [LANES-1:0] mem [DEPTH];

  // Write and registered read share the clock; no reset so the chart survives it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Rhythm-game note sequencer: plays chart rows out of chart_ram paced by the
// frame clock, with a programmable frames-per-row divider, loop/one-shot, pause.
//   Clk, reset      : clock, synchronous active-high reset
//   frame_clk       : frame clock, each rising edge is one tick
//   start/stop/pause: playback control (pulses / pause level)
//   loop_en         : wrap at end of chart (sampled at each end-of-chart)
//   chart_len, rate : rows to play, ticks per row minus one (latched on start)
//   busy/done/wrapped: status (level / pulse / pulse)
//   bus             : chart write bus, wr_err and row outputs
module note_sequencer
  import note_pkg::*;
#(
  parameter int unsigned LANES = DEF_LANES,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                    Clk,
  input  logic                    reset,
  input  logic                    frame_clk,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    pause,
  input  logic                    loop_en,
  input  logic [$clog2(DEPTH):0]  chart_len,
  input  logic [3:0]              rate,
  output logic                    busy,
  output logic                    done,
  output logic                    wrapped,
  note_sequencer_if.slave         bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_PLAY  = ST_PLAY;
  localparam logic [1:0] S_PAUSE = ST_PAUSE;
  localparam logic [1:0] S_DONE  = ST_DONE;

  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    pos_q, pos_d;
  logic [3:0]       div_q, div_d;
  logic [LW-1:0]    len_q, len_d;
  logic [3:0]       rate_q, rate_d;
  logic             frame_q, frame_d;
  logic             looped_q, looped_d;

  // Read pipeline: request issued to RAM, tagged with its row's side info.
  logic             pend_q, pend_d;
  logic [AW-1:0]    pend_pos_q, pend_pos_d;
  logic             pend_wrap_q, pend_wrap_d;
  logic             pend_done_q, pend_done_d;

  logic [LANES-1:0] display_q, display_d;
  logic             row_valid_q, row_valid_d;
  logic [AW-1:0]    position_q, position_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wrapped_q, wrapped_d;
  logic             wr_err_q, wr_err_d;

  logic             tick;
  logic             last_row;
  logic             idle_like;
  logic             issue;
  logic             issue_wrap;
  logic             issue_done;
  logic             clear_disp;
  logic             cancel;
  logic             done_now;
  logic             wr_ok;
  logic [LANES-1:0] ram_rdata;

  assign tick      = frame_clk & ~frame_q;
  assign last_row  = ({1'b0, pos_q} == (len_q - LW'(1)));
  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);

  chart_ram #(
    .LANES (LANES),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (Clk),
    .we    (wr_ok),
    .waddr (bus.wr_addr),
    .wdata (bus.wr_data),
    .re    (issue),
    .raddr (pos_q),
    .rdata (ram_rdata)
  );

  // Playback FSM, divider and row issue.
  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    div_d      = div_q;
    len_d      = len_q;
    rate_d     = rate_q;
    looped_d   = looped_q;
    frame_d    = frame_clk;
    issue      = 1'b0;
    issue_wrap = 1'b0;
    issue_done = 1'b0;
    clear_disp = 1'b0;
    cancel     = 1'b0;
    done_now   = 1'b0;

    if (stop) begin
      state_d    = S_IDLE;
      clear_disp = 1'b1;
      cancel     = 1'b1;
    end else if (start && idle_like) begin
      // Lengths beyond the RAM are clamped so pos never leaves the chart.
      len_d      = (32'(chart_len) > DEPTH) ? LW'(DEPTH) : chart_len;
      rate_d     = rate;
      pos_d      = '0;
      div_d      = rate;
      looped_d   = 1'b0;
      clear_disp = 1'b1;
      cancel     = 1'b1;
      if (chart_len == '0) begin
        state_d  = S_DONE;
        done_now = 1'b1;
      end else begin
        state_d  = S_PLAY;
      end
    end else begin
      case (state_q)
        S_PLAY: begin
          if (pause) begin
            state_d = S_PAUSE;
          end else if (tick) begin
            if (div_q == rate_q) begin
              issue = 1'b1;
              div_d = '0;
              // The first row 0 after a loop restart carries the wrapped flag.
              issue_wrap = looped_q && (pos_q == '0);
              if (issue_wrap) begin
                looped_d = 1'b0;
              end
              if (last_row) begin
                if (loop_en) begin
                  pos_d    = '0;
                  looped_d = 1'b1;
                end else begin
                  issue_done = 1'b1;
                  state_d    = S_DONE;
                end
              end else begin
                pos_d = pos_q + AW'(1);
              end
            end else begin
              div_d = div_q + 4'd1;
            end
          end
        end
        S_PAUSE: begin
          if (!pause) begin
            state_d = S_PLAY;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output stage, read pipeline tags and write acceptance.
  always_comb begin
    pend_d      = issue;
    pend_pos_d  = issue ? pos_q : pend_pos_q;
    pend_wrap_d = issue_wrap;
    pend_done_d = issue_done;

    row_valid_d = pend_q & ~cancel;
    display_d   = display_q;
    position_d  = position_q;
    if (clear_disp) begin
      display_d = '0;
    end else if (pend_q) begin
      display_d  = ram_rdata;
      position_d = pend_pos_q;
    end
    wrapped_d = row_valid_d & pend_wrap_q;
    done_d    = done_now | (row_valid_d & pend_done_q);
    busy_d    = (state_d == S_PLAY) || (state_d == S_PAUSE);

    wr_ok    = bus.wr_en && idle_like && (32'(bus.wr_addr) < DEPTH);
    wr_err_d = bus.wr_en && !wr_ok;
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pos_q       <= '0;
      div_q       <= '0;
      len_q       <= '0;
      rate_q      <= '0;
      frame_q     <= 1'b0;
      looped_q    <= 1'b0;
      pend_q      <= 1'b0;
      pend_pos_q  <= '0;
      pend_wrap_q <= 1'b0;
      pend_done_q <= 1'b0;
      display_q   <= '0;
      row_valid_q <= 1'b0;
      position_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wrapped_q   <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      div_q       <= div_d;
      len_q       <= len_d;
      rate_q      <= rate_d;
      frame_q     <= frame_d;
      looped_q    <= looped_d;
      pend_q      <= pend_d;
      pend_pos_q  <= pend_pos_d;
      pend_wrap_q <= pend_wrap_d;
      pend_done_q <= pend_done_d;
      display_q   <= display_d;
      row_valid_q <= row_valid_d;
      position_q  <= position_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wrapped_q   <= wrapped_d;
      wr_err_q    <= wr_err_d;
    end
  end

  assign busy               = busy_q;
  assign done               = done_q;
  assign wrapped            = wrapped_q;
  assign bus.wr_err         = wr_err_q;
  assign bus.display_signal = display_q;
  assign bus.row_valid      = row_valid_q;
  assign bus.position       = position_q;

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 The block SHALL have parameter LANES, default 4, giving the arrow lanes per chart row.
REQ-002 The block SHALL have parameter DEPTH, default 128, giving the maximum chart rows; AW = $clog2(DEPTH) is derived.
REQ-003 The block SHALL have port Clk, input, 1, the system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, a synchronous, active-high reset.
REQ-005 The block SHALL have port frame_clk, input, 1, the frame clock from the VGA controller, asynchronous in phase to row timing.
REQ-006 The block SHALL have port wr_en / wr_addr / wr_data, input, 1 / AW / LANES, a chart load write.
REQ-007 The block SHALL have port wr_err, output, 1, a 1-cycle pulse when a write is rejected.
REQ-008 The block SHALL have port start / stop / pause, input, 1 each, playback control; start and stop are pulses, pause is a level.
REQ-009 The block SHALL have port loop_en, input, 1, which selects wrap-around (1) or one-shot (0) playback.
REQ-010 The block SHALL have port chart_len, input, AW+1, the number of rows to play; it is latched on start.
REQ-011 The block SHALL have port rate, input, 4, giving frame ticks per row minus one; it is latched on start.
REQ-012 The block SHALL have port display_signal, output, LANES, the current row's notes, held between rows.
REQ-013 The block SHALL have port row_valid, output, 1, a 1-cycle pulse when display_signal updates.
REQ-014 The block SHALL have port position, output, AW, the index of the row most recently presented.
REQ-015 The block SHALL have ports busy, done and wrapped, output, 1 each: busy is high in PLAY or PAUSE; done is a 1-cycle pulse when a one-shot ends; wrapped is a 1-cycle pulse on each loop restart.

Function
REQ-016 Frame tick detection SHALL be frame_clk==1 while the registered frame_clk==0, giving one tick per rising edge.
REQ-017 The FSM SHALL have the states IDLE, PLAY, PAUSE and DONE.
REQ-018 A start in IDLE or DONE SHALL:
- latch chart_len and rate;
- set pos=0 and div_cnt=rate;
- enter PLAY;
- clear display_signal to 0.
REQ-019 A start with chart_len==0 SHALL go to DONE and pulse done the next cycle with no rows emitted; a start in PLAY or PAUSE SHALL be ignored.
REQ-020 In PLAY, on each tick: if div_cnt==rate, a read of row pos SHALL be issued and div_cnt set to 0; otherwise div_cnt SHALL increment.
REQ-021 display_signal, position and row_valid SHALL update exactly 2 Clk cycles after the cycle in which the qualifying tick is detected.
REQ-022 After row pos is issued with pos==len-1, the block SHALL behave as follows:
- loop_en=1: pos wraps to 0 and wrapped pulses with that row's row_valid;
- loop_en=0: the FSM enters DONE, done pulses with that row's row_valid, and display_signal holds.
- Otherwise pos increments.
REQ-023 loop_en SHALL be sampled live at each end-of-chart decision.
REQ-024 pause=1 in PLAY SHALL enter PAUSE, where ticks are ignored and div_cnt and pos freeze; pause=0 SHALL return to PLAY.
REQ-025 A read already issued when pause rises SHALL still complete.
REQ-026 stop SHALL take any state to IDLE in the next cycle, clear display_signal and cancel any in-flight read (no row_valid).
REQ-027 Simultaneous controls SHALL resolve with priority stop > start > pause.
REQ-028 wr_en SHALL be accepted in IDLE or DONE and SHALL write wr_data to wr_addr in the same cycle.
REQ-029 In PLAY or PAUSE, wr_en SHALL be dropped and wr_err pulsed the next cycle; writes with wr_addr >= DEPTH SHALL be dropped with wr_err.

Reset
REQ-030 reset SHALL force, on the next Clk edge:
- state IDLE, pos=0, div_cnt=0, registered frame_clk=0;
- display_signal=0, position=0;
- row_valid, busy, done, wrapped and wr_err all 0.
REQ-031 Chart RAM contents SHALL NOT be reset and SHALL be retained across reset.
REQ-032 reset mid-playback SHALL abort with no further row_valid.

Structure
REQ-033 Package note_pkg SHALL hold the FSM state enum and the default LANES/DEPTH constants.
REQ-034 Sub-module chart_ram (simple dual-port, synchronous 1-cycle read, DEPTH x LANES) SHALL hold the chart; the FSM, divider and edge detector SHALL be in note_sequencer.

Verification
REQ-035 Load rows 0..3 = 1111, 0000, 1010, 0101; set chart_len=4, rate=0, loop_en=0; start; apply 4 frame_clk edges -> display_signal 1111, 0000, 1010, 0101, each 2 cycles after its edge; done pulses with row 3; busy=0.
REQ-036 Same chart with loop_en=1; apply 6 edges -> rows 0,1,2,3,0,1; wrapped pulses with the second row 0.
REQ-037 Set rate=2; apply 9 edges -> row_valid on edges 1, 4 and 7 only.
REQ-038 Hold pause high across 3 edges after row 1 -> no row_valid; release pause; next edge -> row 2.
REQ-039 wr_en during PLAY -> wr_err pulse and RAM unchanged; stop asserted together with start -> IDLE with display_signal=0.
REQ-040 Assert reset mid-chart -> all outputs 0 next cycle; start again -> row 0 replays the pre-reset contents.
